// File: rtl/data_dly_cfg.sv
// Runtime-configurable delay buffer on valid/ready streams: holds items until a programmed
// depth is collected, then streams at full rate; optionally drains on end-of-transaction.
module data_dly_cfg #(
  parameter int unsigned W_DATA  = 16,
  parameter int unsigned MAX_LEN = 8,
  parameter bit          EOT_EN  = 1'b1,
  parameter int unsigned W_CFG   = $clog2(MAX_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [W_CFG-1:0]  i_cfg_data,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  input  logic [W_DATA-1:0] i_din_data,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic [W_DATA-1:0] o_dout_data
);

  localparam int unsigned W_CNT = $clog2(MAX_LEN + 1);
  localparam int unsigned W_PTR = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StStream, StDrain} state_e;

  state_e             r_state, w_state_nxt;
  logic [W_DATA-1:0]  r_mem [MAX_LEN];
  logic [W_PTR-1:0]   r_wr_ptr, r_rd_ptr;
  logic [W_CNT-1:0]   r_cnt, r_len, w_cnt_nxt, w_len_cap;
  logic               w_full, w_wr, w_rd, w_eot, w_cfg_hs;

  assign w_full      = (r_cnt == W_CNT'(MAX_LEN));
  assign w_wr        = i_din_valid && o_din_ready;
  assign w_rd        = o_dout_valid && i_dout_ready;
  assign w_cfg_hs    = i_cfg_valid && o_cfg_ready;
  assign w_eot       = EOT_EN && i_din_data[W_DATA-1];
  assign w_cnt_nxt   = r_cnt + W_CNT'(w_wr) - W_CNT'(w_rd);
  assign o_dout_data = r_mem[r_rd_ptr];

  // Saturate to the storage depth; a zero request behaves as a depth of one.
  always_comb begin
    w_len_cap = W_CNT'(i_cfg_data);
    if (32'(i_cfg_data) >= MAX_LEN) begin
      w_len_cap = W_CNT'(MAX_LEN);
    end else if (i_cfg_data == '0) begin
      w_len_cap = W_CNT'(1);
    end
  end

  always_comb begin
    o_cfg_ready  = 1'b0;
    o_din_ready  = 1'b0;
    o_dout_valid = 1'b0;
    if (!i_rst) begin
      unique case (r_state)
        StIdle:   o_cfg_ready = 1'b1;
        StFill:   o_din_ready = !w_full;
        StStream: begin
          o_din_ready  = !w_full || i_dout_ready;
          o_dout_valid = (r_cnt != '0);
        end
        StDrain:  o_dout_valid = (r_cnt != '0);
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_cfg_hs) w_state_nxt = StFill;
      StFill: begin
        if (w_wr && w_eot) begin
          w_state_nxt = StDrain;
        end else if (w_wr && (w_cnt_nxt >= r_len)) begin
          w_state_nxt = StStream;
        end
      end
      StStream: begin
        if (w_wr && w_eot) begin
          w_state_nxt = StDrain;
        end else if (!w_wr && (w_cnt_nxt == '0)) begin
          w_state_nxt = StFill;
        end
      end
      StDrain: if (w_cnt_nxt == '0) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_len    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cfg_hs) r_len <= w_len_cap;
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == W_PTR'(MAX_LEN - 1)) ? '0 : r_wr_ptr + W_PTR'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == W_PTR'(MAX_LEN - 1)) ? '0 : r_rd_ptr + W_PTR'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din_data;
  end

endmodule

// File: tb/tb_data_dly_cfg.sv
// Directed bench for data_dly_cfg (W_DATA=16, MAX_LEN=8, EOT_EN=1); bit 15 is the eot flag.
module tb_data_dly_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_data = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] din_data = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [15:0] dout_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_dly_cfg #(
    .W_DATA (16),
    .MAX_LEN(8),
    .EOT_EN (1'b1),
    .W_CFG  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_data  (cfg_data),
    .i_din_valid (din_valid),
    .o_din_ready (din_ready),
    .i_din_data  (din_data),
    .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready),
    .o_dout_data (dout_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #4;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [3:0] val);
    cfg_valid = 1'b1;
    cfg_data  = val;
    look();
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int in_i;
    int out_i;
    logic exp_v;

    // Reset state
    tick();
    look();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    rst = 1'b0;
    look();
    chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("idle_din_ready", 32'(din_ready), 32'd0);
    tick();

    // Basic delay of 3
    do_cfg(4'd3);
    dout_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din_valid = (k < 6);
      din_data  = 16'(32'h00A1 + k);
      look();
      if (k < 6) chk("basic_din_ready", 32'(din_ready), 32'd1);
      exp_v = (k >= 3) && (k < 9);
      chk("basic_dout_valid", 32'(dout_valid), 32'(exp_v));
      if (exp_v) chk("basic_dout_data", 32'(dout_data), 32'h00A1 + k - 3);
      tick();
    end

    // Back-pressure at full, then 1-in/1-out across pointer wrap
    do_reset();
    do_cfg(4'd8);
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1;
      din_data  = 16'(32'h0100 + i);
      look();
      chk("bp_fill_din_ready", 32'(din_ready), 32'd1);
      chk("bp_fill_dout_valid", 32'(dout_valid), 32'd0);
      tick();
    end
    din_data = 16'h0108;
    look();
    chk("bp_full_dout_valid", 32'(dout_valid), 32'd1);
    chk("bp_full_din_ready", 32'(din_ready), 32'd0);
    chk("bp_full_dout_data", 32'(dout_data), 32'h0100);
    tick();
    look();
    chk("bp_hold_dout_data", 32'(dout_data), 32'h0100);
    chk("bp_hold_din_ready", 32'(din_ready), 32'd0);
    tick();
    dout_ready = 1'b1;
    in_i  = 8;
    out_i = 0;
    for (int j = 0; j < 20; j++) begin
      din_valid = (in_i < 20);
      din_data  = 16'(32'h0100 + in_i);
      look();
      chk("bp_stream_dout_valid", 32'(dout_valid), 32'd1);
      chk("bp_stream_dout_data", 32'(dout_data), 32'h0100 + out_i);
      if (in_i < 20) chk("bp_stream_din_ready", 32'(din_ready), 32'd1);
      tick();
      out_i++;
      if (in_i < 20) in_i++;
    end
    din_valid = 1'b0;
    look();
    chk("bp_empty_dout_valid", 32'(dout_valid), 32'd0);
    tick();

    // EOT drain before reaching the programmed depth of 5
    do_reset();
    do_cfg(4'd5);
    dout_ready = 1'b1;
    din_valid = 1'b1; din_data = 16'h0031;
    look();
    chk("eot_din_ready", 32'(din_ready), 32'd1);
    chk("eot_w0_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_data = 16'h0032;
    look();
    chk("eot_w1_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_data = 16'h8033;
    look();
    chk("eot_w2_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    look();
    chk("eot_r0_dout_valid", 32'(dout_valid), 32'd1);
    chk("eot_r0_dout_data", 32'(dout_data), 32'h0031);
    chk("eot_drain_din_ready", 32'(din_ready), 32'd0);
    chk("eot_drain_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    look();
    chk("eot_r1_dout_data", 32'(dout_data), 32'h0032);
    tick();
    look();
    chk("eot_r2_dout_valid", 32'(dout_valid), 32'd1);
    chk("eot_r2_dout_data", 32'(dout_data), 32'h8033);
    tick();
    look();
    chk("eot_idle_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("eot_idle_din_ready", 32'(din_ready), 32'd0);
    chk("eot_idle_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b1; din_data = 16'h0041;
    look();
    chk("eot_nocfg_din_ready", 32'(din_ready), 32'd0);
    tick();
    din_valid = 1'b0;

    // Starvation refill with depth 2
    do_cfg(4'd2);
    din_valid = 1'b1; din_data = 16'h0041;
    look();
    chk("starve_din_ready", 32'(din_ready), 32'd1);
    tick();
    din_data = 16'h0042;
    look();
    chk("starve_w1_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    look();
    chk("starve_r0_dout_valid", 32'(dout_valid), 32'd1);
    chk("starve_r0_dout_data", 32'(dout_data), 32'h0041);
    tick();
    look();
    chk("starve_r1_dout_data", 32'(dout_data), 32'h0042);
    tick();
    look();
    chk("starve_empty_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b1; din_data = 16'h0043;
    look();
    chk("starve_refill_din_ready", 32'(din_ready), 32'd1);
    tick();
    din_valid = 1'b0;
    look();
    chk("starve_hold0_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    look();
    chk("starve_hold1_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b1; din_data = 16'h0044;
    look();
    chk("starve_hold2_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    look();
    chk("starve_r2_dout_valid", 32'(dout_valid), 32'd1);
    chk("starve_r2_dout_data", 32'(dout_data), 32'h0043);
    tick();
    look();
    chk("starve_r3_dout_data", 32'(dout_data), 32'h0044);
    tick();

    // Saturation: 15 requested, 8 stored
    do_reset();
    do_cfg(4'd15);
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din_valid = 1'b1;
      din_data  = 16'(32'h0050 + i);
      look();
      chk("sat_fill_dout_valid", 32'(dout_valid), 32'd0);
      tick();
    end
    din_valid = 1'b0;
    look();
    chk("sat_dout_valid", 32'(dout_valid), 32'd1);
    chk("sat_dout_data", 32'(dout_data), 32'h0050);
    tick();

    // Zero depth behaves as one
    do_reset();
    do_cfg(4'd0);
    dout_ready = 1'b1;
    din_valid = 1'b1; din_data = 16'h005A;
    look();
    chk("zero_w_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    look();
    chk("zero_dout_valid", 32'(dout_valid), 32'd1);
    chk("zero_dout_data", 32'(dout_data), 32'h005A);
    tick();
    look();
    chk("zero_after_dout_valid", 32'(dout_valid), 32'd0);
    tick();

    // Reset mid-stream with 4 items held
    do_reset();
    do_cfg(4'd4);
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din_data  = 16'(32'h0061 + i);
      tick();
    end
    din_valid = 1'b0;
    look();
    chk("mid_pre_dout_valid", 32'(dout_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    look();
    chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_din_ready", 32'(din_ready), 32'd0);
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    tick();
    rst = 1'b0;
    look();
    chk("mid_post_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("mid_post_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    do_cfg(4'd1);
    dout_ready = 1'b1;
    din_valid = 1'b1; din_data = 16'h0071;
    look();
    chk("mid_w_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    din_valid = 1'b0;
    look();
    chk("mid_new_dout_valid", 32'(dout_valid), 32'd1);
    chk("mid_new_dout_data", 32'(dout_data), 32'h0071);
    tick();
    look();
    chk("mid_end_dout_valid", 32'(dout_valid), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
